// File: rtl/pipe_game_pkg.sv
// Shared types and geometry defaults for the flappy-style game logic.
// Provides the game state enum, the 3-digit BCD score type and the default
// sprite/pipe/ground geometry used by pipe_collision_score.
package pipe_game_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    PLAY  = 2'd1,
    DEAD  = 2'd2
  } game_state_e;

  typedef logic [11:0] bcd3_t;

  localparam bcd3_t BCD_MAX = 12'h999;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned BIRD_X_DEF   = 160;
  localparam int unsigned BIRD_W_DEF   = 34;
  localparam int unsigned BIRD_H_DEF   = 24;
  localparam int unsigned PIPE_W_DEF   = 90;
  localparam int unsigned CAP_H_DEF    = 33;
  localparam int unsigned GAP_DEF      = 150;
  localparam int unsigned GROUND_Y_DEF = 428;
  localparam int unsigned DEAD_HOLD_DEF = 64;

endpackage

// File: rtl/bcd_counter3.sv
// 3-digit BCD up-counter with synchronous clear; saturates at 999.
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (count enable),
//        count (current BCD value).
module bcd_counter3
  import pipe_game_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  inc,
  output bcd3_t count
);

  bcd3_t count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != BCD_MAX)) begin
      if (count_q[3:0] != 4'd9) begin
        count_q[3:0] <= count_q[3:0] + 4'd1;
      end else begin
        count_q[3:0] <= '0;
        if (count_q[7:4] != 4'd9) begin
          count_q[7:4] <= count_q[7:4] + 4'd1;
        end else begin
          count_q[7:4]  <= '0;
          count_q[11:8] <= count_q[11:8] + 4'd1;
        end
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_collision_score.sv
// Game logic stage: bird/pipe/ground collision, pipe-pass scoring with
// high score, and the READY/PLAY/DEAD state machine advanced by GameTick.
// Ports: Clk, Reset (sync, active-high), GameTick (game step strobe),
//        Button (raw, active-low), PipesPosition/PipesLong/BirdY (geometry),
//        Status (alive), Playing, Score/HighScore (BCD), GameOver (pulse).
module pipe_collision_score
  import pipe_game_pkg::*;
#(
  parameter int unsigned BIRD_X    = BIRD_X_DEF,
  parameter int unsigned BIRD_W    = BIRD_W_DEF,
  parameter int unsigned BIRD_H    = BIRD_H_DEF,
  parameter int unsigned PIPE_W    = PIPE_W_DEF,
  parameter int unsigned CAP_H     = CAP_H_DEF,
  parameter int unsigned GAP       = GAP_DEF,
  parameter int unsigned GROUND_Y  = GROUND_Y_DEF,
  parameter int unsigned DEAD_HOLD = DEAD_HOLD_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        GameTick,
  input  logic        Button,
  input  logic [15:0] PipesPosition,
  input  logic [15:0] PipesLong,
  input  logic [15:0] BirdY,
  output logic        Status,
  output logic        Playing,
  output bcd3_t       Score,
  output bcd3_t       HighScore,
  output logic        GameOver
);

  localparam int unsigned HW = $clog2(DEAD_HOLD + 1);

  game_state_e   state_q;
  logic [2:0]    sync_q;     // [0],[1] synchronizer, [2] previous synced level
  logic          passed_q;
  logic [HW-1:0] hold_q;
  bcd3_t         high_q;
  logic          gameover_q;

  logic          press;
  logic [16:0]   pos_w, long_w, bird_w;
  logic          h_overlap, top_hit, bot_hit, ground_hit, hit;
  logic          pass_now, reload;
  logic          score_clr, score_inc;

  assign press = sync_q[2] & ~sync_q[1];

  // 17-bit zero-extended geometry so sums never wrap
  assign pos_w  = {1'b0, PipesPosition};
  assign long_w = {1'b0, PipesLong};
  assign bird_w = {1'b0, BirdY};

  assign h_overlap  = (17'(BIRD_X + BIRD_W) > pos_w) &&
                      (17'(BIRD_X) < (pos_w + 17'(PIPE_W)));
  assign top_hit    = h_overlap && (bird_w <= (long_w + 17'(CAP_H)));
  assign bot_hit    = h_overlap && ((bird_w + 17'(BIRD_H)) >= (long_w + 17'(GAP)));
  assign ground_hit = (bird_w + 17'(BIRD_H)) >= 17'(GROUND_Y);
  assign hit        = top_hit || bot_hit || ground_hit;

  assign pass_now = !passed_q && ((pos_w + 17'(PIPE_W)) < 17'(BIRD_X));
  assign reload   = pos_w > 17'(BIRD_X + BIRD_W);

  assign score_clr = (state_q == READY) && press;
  assign score_inc = (state_q == PLAY) && GameTick && !hit && pass_now;

  bcd_counter3 u_score (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .count (Score)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= READY;
      sync_q     <= '1;
      passed_q   <= 1'b0;
      hold_q     <= '0;
      high_q     <= '0;
      gameover_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], Button};
      gameover_q <= 1'b0;
      case (state_q)
        READY: begin
          // a tick coinciding with the start press is not evaluated
          if (press) begin
            state_q  <= PLAY;
            passed_q <= 1'b0;
          end
        end
        PLAY: begin
          if (GameTick) begin
            if (hit) begin
              state_q    <= DEAD;
              gameover_q <= 1'b1;
              hold_q     <= HW'(DEAD_HOLD);
              if (Score > high_q) high_q <= Score;
            end else if (pass_now) begin
              passed_q <= 1'b1;
            end else if (reload) begin
              passed_q <= 1'b0;
            end
          end
        end
        DEAD: begin
          if (press && (hold_q == '0)) begin
            state_q <= READY;
          end else if (GameTick && (hold_q != '0)) begin
            hold_q <= hold_q - HW'(1);
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

  assign Status    = (state_q != DEAD);
  assign Playing   = (state_q == PLAY);
  assign HighScore = high_q;
  assign GameOver  = gameover_q;

endmodule

// File: tb/tb_pipe_collision_score.sv
module tb_pipe_collision_score;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        GameTick;
  logic        Button;
  logic [15:0] PipesPosition;
  logic [15:0] PipesLong;
  logic [15:0] BirdY;
  logic        Status;
  logic        Playing;
  logic [11:0] Score;
  logic [11:0] HighScore;
  logic        GameOver;

  pipe_collision_score dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .GameTick      (GameTick),
    .Button        (Button),
    .PipesPosition (PipesPosition),
    .PipesLong     (PipesLong),
    .BirdY         (BirdY),
    .Status        (Status),
    .Playing       (Playing),
    .Score         (Score),
    .HighScore     (HighScore),
    .GameOver      (GameOver)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int score;
    int hi;
    bit status;
    bit playing;
    bit go;
  } exp_t;

  exp_t sb[$];

  // reference model: 0 READY, 1 PLAY, 2 DEAD
  int m_state, m_score, m_hi, m_hold;
  bit m_passed;

  function automatic logic [11:0] to_bcd(int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_hold = 0; m_passed = 0;
  endfunction

  function automatic void model_press();
    if (m_state == 0) begin
      m_state = 1; m_score = 0; m_passed = 0;
    end else if (m_state == 2 && m_hold == 0) begin
      m_state = 0;
    end
  endfunction

  // drive one game tick, push the model's prediction, compare after the edge
  task automatic tick(input int pos, input int plong, input int y);
    exp_t e;
    bit   go, ovl, hitm;
    exp_t got;
    go = 0;
    if (m_state == 1) begin
      ovl  = (194 > pos) && (160 < pos + 90);
      hitm = (ovl && (y <= plong + 33)) || (ovl && (y + 24 >= plong + 150)) || (y + 24 >= 428);
      if (hitm) begin
        m_state = 2; go = 1; m_hold = 64;
        if (m_score > m_hi) m_hi = m_score;
      end else if (!m_passed && (pos + 90 < 160)) begin
        if (m_score < 999) m_score++;
        m_passed = 1;
      end else if (pos > 194) begin
        m_passed = 0;
      end
    end else if (m_state == 2 && m_hold > 0) begin
      m_hold--;
    end
    e.score = m_score; e.hi = m_hi; e.status = (m_state != 2);
    e.playing = (m_state == 1); e.go = go;
    sb.push_back(e);
    PipesPosition = 16'(pos); PipesLong = 16'(plong); BirdY = 16'(y);
    GameTick = 1'b1;
    @(posedge Clk); #1;
    GameTick = 1'b0;
    got = sb.pop_front();
    checks++;
    if (Score !== to_bcd(got.score)) begin
      errors++; $display("FAIL tick_score pos=%0d: got %h want %h", pos, Score, to_bcd(got.score));
    end
    checks++;
    if (HighScore !== to_bcd(got.hi)) begin
      errors++; $display("FAIL tick_hiscore pos=%0d: got %h want %h", pos, HighScore, to_bcd(got.hi));
    end
    checks++;
    if ({Status, Playing, GameOver} !== {got.status, got.playing, got.go}) begin
      errors++; $display("FAIL tick_flags pos=%0d y=%0d: got %b%b%b want %b%b%b", pos, y,
                         Status, Playing, GameOver, got.status, got.playing, got.go);
    end
  endtask

  task automatic press_release();
    Button = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Button = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    model_press();
  endtask

  task automatic test_reset();
    Reset = 1'b1; GameTick = 1'b0; Button = 1'b1;
    PipesPosition = 16'd640; PipesLong = 16'd100; BirdY = 16'd180;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
    checks++;
    if ({Status, Playing, GameOver} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: got %b%b%b want 100", Status, Playing, GameOver);
    end
    checks++;
    if ({Score, HighScore} !== 24'h0) begin
      errors++; $display("FAIL reset_scores: got %h/%h want 000/000", Score, HighScore);
    end
  endtask

  task automatic test_start();
    int n;
    n = 0;
    Button = 1'b0;
    while (!Playing && n < 6) begin
      @(posedge Clk); #1; n++;
    end
    checks++;
    if (!Playing || n > 3) begin
      errors++; $display("FAIL start_latency: got playing=%b after %0d clk want 1 within 3", Playing, n);
    end
    repeat (10 - n) @(posedge Clk);
    #1 Button = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    model_press();
    checks++;
    if ({Status, Playing, Score} !== {2'b11, 12'h000}) begin
      errors++; $display("FAIL start_state: got %b%b %h want 11 000", Status, Playing, Score);
    end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 2; s++) begin
      for (int p = 640; p >= 0; p--) tick(p, 100, 180);
      checks++;
      if (Score !== to_bcd(s + 1)) begin
        errors++; $display("FAIL sweep_total: got %h want %h", Score, to_bcd(s + 1));
      end
    end
  endtask

  task automatic test_top_hit();
    tick(150, 100, 120);
    @(posedge Clk); #1;
    checks++;
    if (GameOver !== 1'b0) begin
      errors++; $display("FAIL gameover_width: got %b want 0", GameOver);
    end
  endtask

  task automatic test_dead_hold();
    for (int i = 0; i < 10; i++) tick(640, 100, 180);
    press_release();
    checks++;
    if (Status !== 1'b0) begin
      errors++; $display("FAIL early_press: got status %b want 0", Status);
    end
    for (int i = 0; i < 54; i++) tick(640, 100, 180);
    press_release();
    checks++;
    if ({Status, Playing} !== 2'b10) begin
      errors++; $display("FAIL restart_ready: got %b%b want 10", Status, Playing);
    end
    press_release();
    checks++;
    if ({Playing, Score, HighScore} !== {1'b1, 12'h000, to_bcd(m_hi)}) begin
      errors++; $display("FAIL replay: got %b %h %h want 1 000 %h", Playing, Score, HighScore, to_bcd(m_hi));
    end
  endtask

  task automatic test_ground();
    tick(640, 100, 403);
    tick(640, 100, 410);
    for (int i = 0; i < 64; i++) tick(640, 100, 180);
    press_release();
  endtask

  task automatic test_press_with_tick();
    PipesPosition = 16'd640; PipesLong = 16'd100; BirdY = 16'd410;
    Button = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    GameTick = 1'b1;
    @(posedge Clk); #1;
    GameTick = 1'b0;
    model_press();
    checks++;
    if ({Status, Playing, GameOver} !== 3'b110) begin
      errors++; $display("FAIL press_tick: got %b%b%b want 110", Status, Playing, GameOver);
    end
    repeat (2) @(posedge Clk);
    #1 Button = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    tick(640, 100, 180);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 1001; i++) begin
      tick(200, 100, 180);
      tick(60, 100, 180);
    end
    checks++;
    if (Score !== 12'h999) begin
      errors++; $display("FAIL saturate: got %h want 999", Score);
    end
    tick(640, 100, 420);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 64; i++) tick(640, 100, 180);
    press_release();
    press_release();
    tick(200, 100, 180);
    tick(60, 100, 180);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    checks++;
    if ({Status, Playing, GameOver, Score, HighScore} !== {3'b100, 24'h0}) begin
      errors++; $display("FAIL reset_mid: got %b%b%b %h %h want 100 000 000",
                         Status, Playing, GameOver, Score, HighScore);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_sweep();
    test_top_hit();
    test_dead_hold();
    test_ground();
    test_press_with_tick();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
